// File: rtl/synth_cfg_spi_writer_pkg.sv
// Shared definitions for the synth cfg SPI writer: cfg byte count, FSM encoding, address helper.
package synth_cfg_spi_writer_pkg;

    localparam int unsigned NUM_CFG_BYTES = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_e;

    function automatic logic [7:0] addr_inc_sat(input logic [7:0] a);
        return (a == 8'hFF) ? 8'hFF : a + 8'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin with registered-history edge detection.
module sync_edge_detect #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    always_comb begin
        q    = sync_q[STAGES-1];
        rise = q & ~prev_q;
        fall = ~q & prev_q;
    end

endmodule

// File: rtl/synth_cfg_spi_writer.sv
// SPI mode-0 write-frame receiver: address byte then data bytes, emitted as one-hot byte strobes.
module synth_cfg_spi_writer
    import synth_cfg_spi_writer_pkg::*;
#(
    parameter int unsigned NUM_BYTES   = NUM_CFG_BYTES,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic [7:0]           cfg_data,
    output logic [NUM_BYTES-1:0] cfg_we,
    output logic                 busy,
    output logic                 frame_err
);

    state_e state_q, state_d;

    logic sclk_rise, sclk_fall_unused, sclk_s_unused;
    logic cs_rise, cs_fall, cs_n_s_unused;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    logic [2:0]           bit_cnt_q, bit_cnt_d, cnt_inc;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           addr_q, addr_d;
    logic                 byte_done_q, byte_done_d;
    logic                 part_err_q, part_err_d;
    logic                 shift_en, byte_end;
    logic [7:0]           cfg_data_q, cfg_data_d;
    logic [NUM_BYTES-1:0] cfg_we_q, cfg_we_d;
    logic                 frame_err_q, frame_err_d;

    sync_edge_detect #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_sclk),
        .q     (sclk_s_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    sync_edge_detect #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_cs_n),
        .q     (cs_n_s_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as the sclk synchronizer so the sampled bit lines up with the detected edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_q <= '0;
        end else begin
            mosi_q[0] <= spi_mosi;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                mosi_q[i] <= mosi_q[i-1];
            end
        end
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cs_fall) state_d = StAddr;
            StAddr:  if (byte_end) state_d = StData;
            StData:  state_d = StData;
            default: state_d = StIdle;
        endcase
        if (cs_fall) state_d = StAddr;
        if (cs_rise) state_d = StIdle;
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Bit datapath; a byte completing on the same clk as cs_rise is still honoured.
    always_comb begin
        shift_en = busy & sclk_rise & ~cs_fall;
        cnt_inc  = bit_cnt_q + 3'd1;
        byte_end = shift_en && (bit_cnt_q == 3'd7);

        bit_cnt_d = shift_en ? cnt_inc : bit_cnt_q;
        if (cs_fall || cs_rise) bit_cnt_d = 3'd0;

        shift_d = shift_en ? {shift_q[6:0], mosi_s} : shift_q;

        addr_d = addr_q;
        if (byte_done_q) addr_d = addr_inc_sat(addr_q);
        if (byte_end && state_q == StAddr) addr_d = {shift_q[6:0], mosi_s};

        byte_done_d = byte_end && (state_q == StData);
        part_err_d  = busy && cs_rise && ((shift_en ? cnt_inc : bit_cnt_q) != 3'd0);
    end

    always_comb begin
        cfg_we_d    = '0;
        cfg_data_d  = cfg_data_q;
        frame_err_d = part_err_q;
        if (byte_done_q) begin
            if (32'(addr_q) < NUM_BYTES) begin
                cfg_data_d = shift_q;
                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                    cfg_we_d[i] = (32'(addr_q) == i);
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            byte_done_q <= 1'b0;
            part_err_q  <= 1'b0;
            cfg_data_q  <= '0;
            cfg_we_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            byte_done_q <= byte_done_d;
            part_err_q  <= part_err_d;
            cfg_data_q  <= cfg_data_d;
            cfg_we_q    <= cfg_we_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cfg_data  = cfg_data_q;
    assign cfg_we    = cfg_we_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_synth_cfg_spi_writer.sv
// Randomized frame-level bench for synth_cfg_spi_writer against a byte-level reference model.
module tb_synth_cfg_spi_writer;

    localparam int unsigned NB   = 6;
    localparam int unsigned SYNC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_sclk, spi_cs_n, spi_mosi;
    logic [7:0]    cfg_data;
    logic [NB-1:0] cfg_we;
    logic          busy, frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0] obs_q[$];
    logic [13:0] exp_q[$];
    int          obs_err = 0;
    int          exp_err = 0;
    logic [7:0]  last_data = 8'h00;
    logic        prev_we = 1'b0;
    logic        mon_en = 1'b0;
    logic [7:0]  frame_bytes [0:15];
    int          lat;

    synth_cfg_spi_writer #(
        .NUM_BYTES   (NB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .cfg_data  (cfg_data),
        .cfg_we    (cfg_we),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observe strobes and error pulses away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                if (cfg_we != '0) begin
                    check_val("we_onehot", 32'($countones(cfg_we)), 32'd1);
                    check_val("we_width", 32'(prev_we), 32'd0);
                    obs_q.push_back({cfg_we, cfg_data});
                end
                if (frame_err) obs_err++;
            end
            prev_we = (cfg_we != '0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference: byte 0 is the address, each following full byte targets addr+k (saturating);
    // in range -> one strobe, out of range -> one error; trailing partial byte -> one error.
    task automatic model_frame(input int nb, input int extra);
        int a;
        if (nb >= 1) begin
            a = int'(frame_bytes[0]);
            for (int k = 1; k < nb; k++) begin
                if (a < NB) begin
                    exp_q.push_back({6'(1 << a), frame_bytes[k]});
                    last_data = frame_bytes[k];
                end else begin
                    exp_err++;
                end
                if (a < 255) a++;
            end
        end
        if (extra > 0) exp_err++;
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input int half, input bit last_cs);
        for (int i = 0; i < n; i++) begin
            spi_mosi = v[7-i];
            repeat (half) @(negedge clk);
            spi_sclk = 1'b1;
            if (last_cs && i == n - 1) spi_cs_n = 1'b1;
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_high(output int l);
        spi_cs_n = 1'b1;
        l = 0;
        while (busy && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
        @(negedge clk);
        repeat (6) @(negedge clk);
    endtask

    task automatic run_frame(input int nb, input int extra, input int half, input bit with_last,
                             output int l);
        model_frame(nb, extra);
        cs_low();
        for (int k = 0; k < nb; k++) begin
            send_bits(frame_bytes[k], 8, half, with_last && (k == nb - 1));
        end
        if (extra > 0) send_bits(8'($urandom), extra, half, 1'b0);
        cs_high(l);
    endtask

    task automatic compare_frame();
        check_val("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check_val("wr_we", 32'(obs_q[i][13:8]), 32'(exp_q[i][13:8]));
            check_val("wr_data", 32'(obs_q[i][7:0]), 32'(exp_q[i][7:0]));
        end
        check_val("n_frame_err", 32'(obs_err), 32'(exp_err));
        check_val("cfg_data_hold", 32'(cfg_data), 32'(last_data));
        check_val("busy_idle", 32'(busy), 32'd0);
        obs_q.delete();
        exp_q.delete();
        obs_err = 0;
        exp_err = 0;
    endtask

    int nb, extra, half;
    bit with_last;

    initial begin
        reset    = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;

        // Reset held with random pin activity
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            spi_sclk = 1'($urandom);
            spi_cs_n = 1'($urandom);
            spi_mosi = 1'($urandom);
            if (i % 5 == 4) check_val("reset_outs", 32'({cfg_we, cfg_data, busy, frame_err}), 32'd0);
        end
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        // Single write at clk/8, with busy-release latency
        frame_bytes[0] = 8'h02;
        frame_bytes[1] = 8'hA5;
        run_frame(2, 0, 4, 1'b0, lat);
        check_val("busy_fall_lat", 32'(lat), 32'(SYNC + 1));
        compare_frame();

        // Burst running past the last cfg byte
        frame_bytes[0] = 8'h04;
        frame_bytes[1] = 8'h11;
        frame_bytes[2] = 8'h22;
        frame_bytes[3] = 8'h33;
        run_frame(4, 0, 4, 1'b0, lat);
        compare_frame();

        // Partial data byte, then a clean frame
        frame_bytes[0] = 8'h01;
        run_frame(1, 5, 4, 1'b0, lat);
        compare_frame();
        frame_bytes[0] = 8'h00;
        frame_bytes[1] = 8'h3C;
        run_frame(2, 0, 4, 1'b0, lat);
        compare_frame();

        // Asynchronous reset mid data byte
        cs_low();
        send_bits(8'h02, 8, 4, 1'b0);
        send_bits(8'hF0, 4, 4, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_reset_outs", 32'({cfg_we, cfg_data, busy, frame_err}), 32'd0);
        repeat (3) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        reset    = 1'b0;
        last_data = 8'h00;
        repeat (6) @(negedge clk);
        compare_frame();
        frame_bytes[0] = 8'h05;
        frame_bytes[1] = 8'hFF;
        run_frame(2, 0, 4, 1'b0, lat);
        compare_frame();

        // Stress: clk/4, full 6-byte burst, cs_n rising with the final sclk edge
        frame_bytes[0] = 8'h00;
        for (int k = 1; k <= 6; k++) frame_bytes[k] = 8'($urandom);
        run_frame(7, 0, 2, 1'b1, lat);
        compare_frame();

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            nb    = int'($urandom_range(0, 5));
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            half  = int'($urandom_range(2, 4));
            with_last = (extra == 0) && (nb > 0) && ($urandom_range(0, 1) == 1);
            frame_bytes[0] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7))
                                                          : 8'($urandom_range(250, 255));
            for (int k = 1; k < 8; k++) frame_bytes[k] = 8'($urandom);
            run_frame(nb, extra, half, with_last, lat);
            if ($urandom_range(0, 3) == 0) begin
                // sclk toggling with cs_n high must be ignored
                for (int p = 0; p < 3; p++) begin
                    spi_sclk = 1'b1;
                    repeat (2) @(negedge clk);
                    spi_sclk = 1'b0;
                    repeat (2) @(negedge clk);
                end
                repeat (6) @(negedge clk);
            end
            compare_frame();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
